fb_scanout: RTL and testbench
=============================

# fb_scanout

Frame-buffer scanout reader: prefetches one display line ahead of the VGA beam from a word-organised 1-bit-per-pixel frame-buffer read port into a ping-pong line buffer. It delivers `read_data` for the current `ReadX`/`ReadY` to `color_mapper`. It is the read end of the frame buffer whose write end is the draw/clear pipeline. It runs on the 50 MHz `Clk`, with `ReadX`/`ReadY` supplied by `VGA_controller`, each value held for 2 `Clk` cycles.

## Interface
Parameters:
- `H_PIX`, 640: visible pixels per line.
- `V_PIX`, 480: visible lines.
- `V_TOTAL`, 525: total lines per frame, including vblank.
- `WORD_W`, 16: pixels per memory word. Fixed at 16.
- `ADDR_W`, 15: memory word address width.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `ReadX` in 10: beam column from `VGA_controller`.
- `ReadY` in 10: beam row from `VGA_controller`.
- `mem_req` out 1: read request.
- `mem_addr` out `ADDR_W`: word address.
- `mem_ack` in 1: word accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in `WORD_W`: read data.
- `read_data` out 1: pixel value to `color_mapper`.
- `fetch_busy` out 1: line fetch in progress.
- `underrun` out 1: one-cycle pulse when a visible line starts without valid data.

## Operation
Memory map and addressing:
- Pixel (x, y) is stored in word y*40 + x[9:4], at bit x[3:0]; bit 0 is the leftmost pixel.
- Base address = (line<<5) + (line<<3). No multiplier is used.

Fetch trigger:
- Rising edge of the condition (`ReadX` == `H_PIX`), detected against the registered previous `ReadX`.
- The trigger fires only when `ReadY` < `V_PIX`-1 or `ReadY` == `V_TOTAL`-1.
- Target line = (`ReadY` == `V_TOTAL`-1) ? 0 : `ReadY`+1.

Line buffers:
- Two banks of 40 x `WORD_W`.
- The fetch writes bank target[0]; the display reads bank `ReadY`[0].
- Each bank has a `valid` flag. It is cleared when a fetch into that bank starts and set when word 39 of that fetch is acked.

FSM states: IDLE, FETCH.
- IDLE -> FETCH on trigger:
  - latch the target line;
  - idx = 0;
  - `mem_req`=1;
  - `mem_addr` = base.
- FETCH, on each `mem_ack`:
  - write `mem_rdata` to bank[target[0]][idx];
  - if idx == 39: go to IDLE, `mem_req`=0, set `valid`;
  - otherwise idx++ and `mem_addr`++ in the next cycle, with `mem_req` held high.
- FETCH without ack: `mem_req` and `mem_addr` hold stable.
- A trigger arriving in FETCH is ignored. The current fetch continues.

Pixel path:
- `read_data` = bank[`ReadY`[0]][`ReadX`[9:4]][`ReadX`[3:0]], registered.
- `read_data` is forced to 0 when any of these hold:
  - `ReadX` >= `H_PIX`;
  - `ReadY` >= `V_PIX`;
  - the bank's `valid` = 0.

Underrun:
- `underrun` pulses for 1 cycle on the rising edge of (`ReadX` == 0) when `ReadY` < `V_PIX` and bank[`ReadY`[0]].`valid` = 0.

`fetch_busy` = (state == FETCH).

## Timing
Reset values:
- `mem_req`=0, `mem_addr`=0, `read_data`=0, `fetch_busy`=0, `underrun`=0.
- Both `valid` flags = 0; state = IDLE.
- Buffer contents are don't-care. Reading them is masked by `valid` = 0.

`Reset_n` asserted mid-fetch:
- `mem_req` drops asynchronously.
- The fetch is abandoned and is not resumed after reset.

Latencies:
- Trigger edge -> `mem_req` high: 1 cycle.
- Fetch with `mem_ack` held high: 40 cycles from the first `mem_req` to IDLE.
- Horizontal-blank budget: 160 pixels = 320 `Clk` cycles. Average ack wait of up to 7 cycles per word is tolerated.
- `ReadX`/`ReadY` -> `read_data`: 1 `Clk` cycle.

Simultaneous fetch write and display read never address the same bank for a visible line. Line 0 is fetched during line `V_TOTAL`-1, which is not displayed.

## Test plan
- Reset, then sweep `ReadX`/`ReadY` over a full frame with memory returning word = addr[15:0] and `mem_ack`=1:
  - line 0 fetch uses addresses 0..39 during `ReadY`=524;
  - `read_data` at (x=17, y=1) equals bit 1 of word 41.
- Memory all-ones, `mem_ack` every 4th cycle:
  - `read_data`=1 for all visible pixels;
  - `underrun` never asserts.
- `mem_ack` held 0 during the whole line-0 fetch:
  - `underrun` pulses once at (0,0);
  - `read_data`=0 for line 0;
  - `mem_req`/`mem_addr` stay stable.
- Deassert `Reset_n` at fetch word 20:
  - `mem_req`=0 immediately;
  - `fetch_busy`=0;
  - after release, `read_data`=0 until the next completed fetch.
- Trigger edge while in FETCH (`ReadX` forced to 640 twice):
  - the second trigger is ignored;
  - exactly 40 acks occur, and addresses are contiguous.
- `ReadX` in 640..799 or `ReadY` in 480..524 with memory all-ones: `read_data`=0.

Source files
------------

// File: rtl/fb_scanout.sv
// fb_scanout: prefetches the next display line from a word-organised 1 bpp frame buffer
// into a ping-pong line buffer and serves the current beam pixel to the colour mapper.
module fb_scanout #(
  parameter int H_PIX   = 640,
  parameter int V_PIX   = 480,
  parameter int V_TOTAL = 525,
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        ReadX,
  input  logic [9:0]        ReadY,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              read_data,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int         LINE_WORDS     = 40;
  localparam logic [9:0] X_BLANK        = 10'(H_PIX);
  localparam logic [9:0] Y_VIS          = 10'(V_PIX);
  localparam logic [9:0] Y_PREFETCH_MAX = 10'(V_PIX - 1);
  localparam logic [9:0] Y_LAST         = 10'(V_TOTAL - 1);
  localparam logic [5:0] LAST_IDX       = 6'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  // line * 40 built from two shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] line);
    logic [ADDR_W-1:0] l;
    l = ADDR_W'(line);
    return (l << 3'd5) + (l << 3'd3);
  endfunction

  state_t            state_r;
  logic [5:0]        idx_r;
  logic              tgt_bank_r;
  logic [1:0]        valid_r;
  logic [9:0]        prev_x_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              fetch_busy_r;
  logic              read_data_r;
  logic              underrun_r;
  logic [WORD_W-1:0] line_buf_r [0:1][0:LINE_WORDS-1];

  logic       trigger_s;
  logic [9:0] target_s;
  logic       disp_bank_s;
  logic [5:0] word_sel_s;
  logic       visible_s;
  logic       pixel_s;
  logic       underrun_s;

  // Fetch trigger: rising edge of ReadX == H_PIX on a line that has a successor to prefetch
  always_comb begin
    trigger_s = 1'b0;
    target_s  = 10'd0;
    if ((ReadX == X_BLANK) && (prev_x_r != X_BLANK) &&
        ((ReadY < Y_PREFETCH_MAX) || (ReadY == Y_LAST))) begin
      trigger_s = 1'b1;
    end else begin
      trigger_s = 1'b0;
    end
    if (ReadY == Y_LAST) begin
      target_s = 10'd0;
    end else begin
      target_s = ReadY + 10'd1;
    end
  end

  // Display side: select the beam pixel and detect a visible line starting on an empty bank
  always_comb begin
    disp_bank_s = ReadY[0];
    visible_s   = (ReadX < X_BLANK) && (ReadY < Y_VIS);
    if (visible_s) begin
      word_sel_s = ReadX[9:4];
    end else begin
      word_sel_s = 6'd0;
    end
    pixel_s    = line_buf_r[disp_bank_s][word_sel_s][ReadX[3:0]] & visible_s & valid_r[disp_bank_s];
    underrun_s = (ReadX == 10'd0) && (prev_x_r != 10'd0) && (ReadY < Y_VIS) && !valid_r[disp_bank_s];
  end

  // Line fetch sequencer and bank valid flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 6'd0;
      tgt_bank_r   <= 1'b0;
      valid_r      <= 2'b00;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      fetch_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_r              <= ST_FETCH;
            tgt_bank_r           <= target_s[0];
            idx_r                <= 6'd0;
            valid_r[target_s[0]] <= 1'b0;
            mem_req_r            <= 1'b1;
            mem_addr_r           <= line_base(target_s);
            fetch_busy_r         <= 1'b1;
          end
        end
        ST_FETCH: begin
          // a trigger seen here is deliberately dropped; the running fetch owns the port
          if (mem_ack) begin
            if (idx_r == LAST_IDX) begin
              state_r             <= ST_IDLE;
              mem_req_r           <= 1'b0;
              fetch_busy_r        <= 1'b0;
              valid_r[tgt_bank_r] <= 1'b1;
            end else begin
              idx_r      <= idx_r + 6'd1;
              mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_req_r    <= 1'b0;
          fetch_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer write port; contents need no reset because valid masks them
  always_ff @(posedge Clk) begin
    if ((state_r == ST_FETCH) && mem_ack) begin
      line_buf_r[tgt_bank_r][idx_r] <= mem_rdata;
    end
  end

  // Registered pixel, underrun pulse and previous-column tracker
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_x_r    <= 10'd0;
      read_data_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      prev_x_r    <= ReadX;
      read_data_r <= pixel_s;
      underrun_r  <= underrun_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign fetch_busy = fetch_busy_r;
  assign read_data  = read_data_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: constant pixel table, directed fetch corner cases,
// and random beam/memory traffic checked against a line-level behavioural model.
module tb_fb_scanout;

  logic        Clk;
  logic        Reset_n;
  logic [9:0]  ReadX;
  logic [9:0]  ReadY;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        read_data;
  logic        fetch_busy;
  logic        underrun;

  fb_scanout dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReadX(ReadX), .ReadY(ReadY),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .read_data(read_data), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int n_err = 0;
  int n_chk = 0;

  // environment knobs
  int mem_mode = 0;   // 0: word = address, 1: all ones, 2: random contents
  int ack_mode = 0;   // 0: always, 1: every 4th cycle, 2: never, 3: random
  int cyc_cnt  = 0;
  bit chk_ones = 1'b0;
  bit chk_zero = 1'b0;
  int und_cnt  = 0;
  int ack_q[$];
  logic [15:0] rand_mem [32768];

  // line-level reference: what each bank holds, whether it is complete, the pending fetch
  logic [15:0] m_buf [2][40];
  bit [1:0]    m_valid;
  bit          m_busy;
  int          m_line, m_bank, m_cnt, m_prevx;

  typedef struct {
    int   x;
    int   y;
    int   blank_y;
    logic exp;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [15:0] mem_word(input int addr);
    case (mem_mode)
      0:       return 16'(addr);
      1:       return 16'hFFFF;
      default: return rand_mem[addr & 32'h7FFF];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", name, act, exp, ReadX, ReadY, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 2'b00;
    m_cnt   = 0;
    m_prevx = 0;
  endtask

  // one clock with beam at (x,y): memory responds, model predicts, outputs compared after the edge
  task automatic cyc(input int x, input int y);
    logic ack, e_rd, e_und, vis;
    int   bank;
    ReadX = 10'(x);
    ReadY = 10'(y);
    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = (cyc_cnt % 4 == 0);
      2:       ack = 1'b0;
      default: ack = 1'($urandom_range(0, 1));
    endcase
    ack       = ack && mem_req;
    mem_ack   = ack;
    mem_rdata = mem_word(int'(mem_addr));
    vis  = (x < 640) && (y < 480);
    bank = y % 2;
    if (vis) e_rd = m_valid[bank] && m_buf[bank][x / 16][x % 16];
    else     e_rd = 1'b0;
    e_und = (x == 0) && (m_prevx != 0) && (y < 480) && !m_valid[bank];
    if (ack) ack_q.push_back(int'(mem_addr));
    if (m_busy) begin
      if (ack) begin
        m_buf[m_bank][m_cnt] = mem_word(m_line * 40 + m_cnt);
        m_cnt++;
        if (m_cnt == 40) begin
          m_busy          = 1'b0;
          m_valid[m_bank] = 1'b1;
        end
      end
    end else if (x == 640 && m_prevx != 640 && (y < 479 || y == 524)) begin
      m_line          = (y == 524) ? 0 : y + 1;
      m_bank          = m_line % 2;
      m_valid[m_bank] = 1'b0;
      m_busy          = 1'b1;
      m_cnt           = 0;
    end
    m_prevx = x;
    cyc_cnt++;
    @(posedge Clk);
    #1;
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("fetch_busy", 32'(fetch_busy), 32'(m_busy));
    if (m_busy) chk("mem_addr", 32'(mem_addr), 32'(m_line * 40 + m_cnt));
    chk("read_data", 32'(read_data), 32'(e_rd));
    chk("underrun", 32'(underrun), 32'(e_und));
    if (underrun) und_cnt++;
    if (chk_ones) chk("ones_pix", 32'(read_data), 32'(vis));
    if (chk_zero) chk("zero_pix", 32'(read_data), 32'd0);
  endtask

  task automatic hold(input int x, input int y);
    cyc(x, y);
    cyc(x, y);
  endtask

  task automatic blank(input int y);
    for (int x = 640; x < 800; x++) hold(x, y);
  endtask

  task automatic vis_part(input int y);
    hold(0, y);
    for (int i = 0; i < 10; i++) hold(int'($urandom_range(0, 639)), y);
  endtask

  task automatic line(input int y);
    vis_part(y);
    blank(y);
  endtask

  initial begin
    bit found;
    int ylist[12];

    for (int a = 0; a < 32768; a++) rand_mem[a] = 16'($urandom);
    tbl[0]  = '{0,   0,   -1, 1'b0};
    tbl[1]  = '{16,  0,   -1, 1'b1};
    tbl[2]  = '{17,  0,   -1, 1'b0};
    tbl[3]  = '{33,  0,   -1, 1'b1};
    tbl[4]  = '{624, 0,   -1, 1'b1};
    tbl[5]  = '{629, 0,   -1, 1'b1};
    tbl[6]  = '{628, 0,   -1, 1'b0};
    tbl[7]  = '{700, 0,   -1, 1'b0};
    tbl[8]  = '{17,  1,    0, 1'b0};
    tbl[9]  = '{16,  1,   -1, 1'b1};
    tbl[10] = '{19,  1,   -1, 1'b1};
    tbl[11] = '{3,   1,   -1, 1'b1};
    tbl[12] = '{0,   1,   -1, 1'b0};
    tbl[13] = '{639, 1,   -1, 1'b0};
    tbl[14] = '{630, 1,   -1, 1'b1};
    tbl[15] = '{10,  481, -1, 1'b0};
    tbl[16] = '{17,  481, -1, 1'b0};

    // reset state
    Reset_n   = 1'b0;
    ReadX     = 10'd0;
    ReadY     = 10'd0;
    mem_ack   = 1'b0;
    mem_rdata = 16'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();

    // word = address, ack always: line 0 fetched during line 524 from addresses 0..39
    mem_mode = 0;
    ack_mode = 0;
    ack_q.delete();
    blank(524);
    chk("l0_ack_count", 32'(ack_q.size()), 32'd40);
    for (int i = 0; i < ack_q.size() && i < 40; i++) chk("l0_addr", 32'(ack_q[i]), 32'(i));
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].blank_y >= 0) blank(tbl[i].blank_y);
      hold(tbl[i].x, tbl[i].y);
      chk("tbl_pix", 32'(read_data), 32'(tbl[i].exp));
    end

    // all-ones memory, ack every 4th cycle: every visible pixel is 1, no underrun
    mem_mode = 1;
    ack_mode = 1;
    chk_ones = 1'b1;
    und_cnt  = 0;
    line(524);
    line(0);
    line(1);
    line(2);
    line(3);
    chk("slow_ack_underrun", 32'(und_cnt), 32'd0);
    chk_ones = 1'b0;

    // no ack during the line 0 fetch: one underrun at (0,0), line 0 stays dark
    mem_mode = 2;
    ack_mode = 2;
    line(524);
    und_cnt  = 0;
    chk_zero = 1'b1;
    vis_part(0);
    ack_mode = 0;
    blank(0);
    chk_zero = 1'b0;
    chk("stall_underrun", 32'(und_cnt), 32'd1);

    // reset while requesting word 20
    mem_mode = 1;
    ack_mode = 0;
    found    = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(640, 524);
      if (m_busy && m_cnt == 20) found = 1'b1;
    end
    chk("reach_word20", 32'(found), 32'd1);
    mem_ack = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(fetch_busy), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    chk_zero = 1'b1;
    vis_part(0);
    blank(0);
    chk_zero = 1'b0;
    chk_ones = 1'b1;
    line(1);
    chk_ones = 1'b0;

    // second trigger edge during a fetch is ignored
    mem_mode = 2;
    ack_mode = 1;
    ack_q.delete();
    hold(640, 5);
    hold(641, 5);
    hold(641, 5);
    hold(640, 5);
    for (int x = 642; x < 800; x++) hold(x, 5);
    chk("dbl_ack_count", 32'(ack_q.size()), 32'd40);
    for (int i = 0; i < ack_q.size() && i < 40; i++) chk("dbl_addr", 32'(ack_q[i]), 32'(240 + i));

    // random memory and ack timing over a jumbled line sequence
    ack_mode = 3;
    ylist = '{524, 0, 1, 2, 3, 479, 490, 524, 0, 1, 100, 101};
    for (int i = 0; i < 12; i++) line(ylist[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
